// File: rtl/uart_rx_sampler.sv
// UART receive stage: synchronizes rx, qualifies a start bit on 16x baud ticks,
// shifts in 7/8 data bits with optional parity, and holds the character for the host.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       rx_busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             hist_q, hist_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   cfg_bit8_q, cfg_bit8_d;
  logic                   cfg_par_q, cfg_par_d;
  logic                   cfg_odd_q, cfg_odd_d;
  logic                   perr_q, perr_d;
  logic [7:0]             data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_q, ferr_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;

  logic rx_s;
  logic sample;
  logic par_calc;
  logic load;
  logic load_ferr;

  always_comb begin
    rx_s       = sync_q[SYNC_STAGES-1];
    // majority of the two previous tick samples and the current one
    sample     = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
    hist_d     = hist_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    cfg_bit8_d = cfg_bit8_q;
    cfg_par_d  = cfg_par_q;
    cfg_odd_d  = cfg_odd_q;
    perr_d     = perr_q;
    par_calc   = 1'b0;
    load       = 1'b0;
    load_ferr  = 1'b0;

    if (baud_clock) begin
      hist_d = {hist_q[1:0], rx_s};
      case (state_q)
        IDLE: begin
          if (rx_s) begin
            cnt_d = 4'd0;
          end else if (cnt_q == 4'd7) begin
            cnt_d      = 4'd0;
            bitcnt_d   = 3'd0;
            shift_d    = 8'd0;
            perr_d     = 1'b0;
            cfg_bit8_d = bit8;
            cfg_par_d  = parity_en;
            cfg_odd_d  = odd_n_even;
            state_d    = DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            shift_d  = {sample, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == (cfg_bit8_q ? 3'd7 : 3'd6)) begin
              state_d = cfg_par_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            par_calc = (cfg_bit8_q ? ^shift_q : ^shift_q[7:1]) ^ sample;
            perr_d   = cfg_odd_q ? ~par_calc : par_calc;
            state_d  = STOP;
          end
        end
        STOP: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            load      = 1'b1;
            load_ferr = ~sample;
            cnt_d     = 4'd0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d     = (state_d != IDLE);
    data_d     = data_q;
    ready_d    = ready_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    ovf_d      = ovf_q;

    // a completing character beats a same-cycle read
    if (load) begin
      if (ready_q && !rd_en) begin
        ovf_d = 1'b1;
      end else begin
        data_d     = cfg_bit8_q ? shift_q : {1'b0, shift_q[7:1]};
        ready_d    = 1'b1;
        perr_out_d = cfg_par_q & perr_q;
        ferr_d     = load_ferr;
        ovf_d      = 1'b0;
      end
    end else if (rd_en) begin
      ready_d    = 1'b0;
      perr_out_d = 1'b0;
      ferr_d     = 1'b0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sync_q     <= '1;
      hist_q     <= 3'b111;
      cnt_q      <= 4'd0;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'd0;
      cfg_bit8_q <= 1'b0;
      cfg_par_q  <= 1'b0;
      cfg_odd_q  <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= 8'd0;
      ready_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      cfg_bit8_q <= cfg_bit8_d;
      cfg_par_q  <= cfg_par_d;
      cfg_odd_q  <= cfg_odd_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_ready    = ready_q;
  assign parity_err  = perr_out_q;
  assign framing_err = ferr_q;
  assign overflow    = ovf_q;
  assign rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: frames are driven tick by tick; a frame-level model
// predicts when each character lands and what the holding register must show.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_clock = 1'b0;
  logic       rx = 1'b1;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, parity_err, framing_err, overflow, rx_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_sampler #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even), .rd_en(rd_en),
    .rx_data(rx_data), .rx_ready(rx_ready), .parity_err(parity_err),
    .framing_err(framing_err), .overflow(overflow), .rx_busy(rx_busy)
  );

  typedef struct {
    int         start_tick;
    int         load_tick;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  frame_t     pend[$];
  int         tick_no = 0;
  logic [7:0] m_data = 8'd0;
  logic       m_ready = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0, m_busy = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a character lands on the stop-bit centre tick.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data  <= 8'd0;
      m_ready <= 1'b0;
      m_perr  <= 1'b0;
      m_ferr  <= 1'b0;
      m_ovf   <= 1'b0;
      m_busy  <= 1'b0;
      pend.delete();
    end else begin
      if (baud_clock) tick_no <= tick_no + 1;
      if (baud_clock && pend.size() > 0 && tick_no == pend[0].start_tick) m_busy <= 1'b1;
      if (baud_clock && pend.size() > 0 && tick_no == pend[0].load_tick) begin
        m_busy <= 1'b0;
        if (m_ready && !rd_en) begin
          m_ovf <= 1'b1;
        end else begin
          m_data  <= pend[0].data;
          m_ready <= 1'b1;
          m_perr  <= pend[0].perr;
          m_ferr  <= pend[0].ferr;
          m_ovf   <= 1'b0;
        end
        void'(pend.pop_front());
      end else if (rd_en) begin
        m_ready <= 1'b0;
        m_perr  <= 1'b0;
        m_ferr  <= 1'b0;
        m_ovf   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_rx_data", rx_data, m_data);
      chk("cyc_rx_ready", {7'd0, rx_ready}, {7'd0, m_ready});
      chk("cyc_parity_err", {7'd0, parity_err}, {7'd0, m_perr});
      chk("cyc_framing_err", {7'd0, framing_err}, {7'd0, m_ferr});
      chk("cyc_overflow", {7'd0, overflow}, {7'd0, m_ovf});
      chk("cyc_rx_busy", {7'd0, rx_busy}, {7'd0, m_busy});
    end
  end

  // One baud tick is four clk; rx changes three clk before the tick pulse.
  task automatic do_tick(input logic v, input logic rd);
    rx = v;
    repeat (3) begin @(posedge clk); #1; end
    baud_clock = 1'b1;
    rd_en = rd;
    @(posedge clk); #1;
    baud_clock = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic read_pulse();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, rx_data, 8'h00);
    chk({tag, "_ready"}, {7'd0, rx_ready}, 8'h00);
    chk({tag, "_perr"}, {7'd0, parity_err}, 8'h00);
    chk({tag, "_ferr"}, {7'd0, framing_err}, 8'h00);
    chk({tag, "_ovf"}, {7'd0, overflow}, 8'h00);
    chk({tag, "_busy"}, {7'd0, rx_busy}, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic b8, input logic pe,
                            input logic odd, input logic pflip, input logic stopv,
                            input int glitch_slot, input int reset_slot, input logic rd_last);
    int         nb, pb, nslots, k;
    logic [11:0] line;
    logic [7:0] dm;
    logic       pbit, v;
    nb     = b8 ? 8 : 7;
    pb     = pe ? 1 : 0;
    nslots = nb + pb + 2;
    dm     = b8 ? d : {1'b0, d[6:0]};
    pbit   = (^dm) ^ odd ^ pflip;
    line   = '1;
    line[0] = 1'b0;
    for (int i = 0; i < nb; i++) line[1+i] = d[i];
    if (pe) line[1+nb] = pbit;
    line[nslots-1] = stopv;
    bit8 = b8;
    parity_en = pe;
    odd_n_even = odd;
    k = tick_no;
    pend.push_back('{start_tick: k + 7, load_tick: k + 23 + 16 * (nb + pb), data: dm,
                     perr: pe && (((^dm) ^ pbit) != odd), ferr: ~stopv});
    for (int j = 0; j < nslots; j++) begin
      for (int s = 0; s < 16; s++) begin
        v = line[j];
        if (j == glitch_slot && s == 7) v = ~v;
        // a low stop bit is released early so it cannot qualify as a new start
        if (j == nslots - 1 && s >= 12) v = 1'b1;
        if (j == reset_slot && s == 8) begin
          reset = 1'b1;
          #1;
          check_all_zero("rst_mid");
          rx = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          return;
        end
        do_tick(v, rd_last && j == nslots - 1 && s == 7);
        if (j == 0 && s == 9) begin
          bit8 = 1'($urandom_range(0, 1));
          parity_en = 1'($urandom_range(0, 1));
          odd_n_even = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) do_tick(1'b1, 1'b0);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    chk("8n1_data", rx_data, 8'hA5);
    chk("8n1_ready", {7'd0, rx_ready}, 8'h01);
    chk("8n1_perr", {7'd0, parity_err}, 8'h00);
    chk("8n1_ferr", {7'd0, framing_err}, 8'h00);
    read_pulse();
    chk("8n1_ready_after_rd", {7'd0, rx_ready}, 8'h00);

    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    chk("7e1_data", rx_data, 8'h41);
    chk("7e1_perr", {7'd0, parity_err}, 8'h00);
    read_pulse();
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
    chk("7e1_bad_data", rx_data, 8'h41);
    chk("7e1_bad_perr", {7'd0, parity_err}, 8'h01);
    read_pulse();

    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0);
    chk("8o1_data", rx_data, 8'hFF);
    chk("8o1_ferr", {7'd0, framing_err}, 8'h01);
    chk("8o1_perr", {7'd0, parity_err}, 8'h00);
    repeat (8) do_tick(1'b1, 1'b0);
    read_pulse();

    repeat (5) do_tick(1'b0, 1'b0);
    repeat (20) do_tick(1'b1, 1'b0);
    chk("false_start_busy", {7'd0, rx_busy}, 8'h00);
    chk("false_start_ready", {7'd0, rx_ready}, 8'h00);

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1, 1'b0);
    chk("glitch_data", rx_data, 8'h3C);
    read_pulse();

    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", {7'd0, overflow}, 8'h01);
    read_pulse();
    chk("ovr_flag_after_rd", {7'd0, overflow}, 8'h00);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
    chk("ovr_rd_data", rx_data, 8'h22);
    chk("ovr_rd_flag", {7'd0, overflow}, 8'h00);
    chk("ovr_rd_ready", {7'd0, rx_ready}, 8'h01);
    read_pulse();

    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    send_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5, 1'b0);
    repeat (3) do_tick(1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    chk("post_rst_data", rx_data, 8'h5A);
    chk("post_rst_ready", {7'd0, rx_ready}, 8'h01);
    repeat (4) do_tick(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
